// File: rtl/conv_ctrl_pkg.sv
// Shared types and helpers for the conv2d engine control blocks.
package conv_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'b00,
    S_WAIT    = 2'b01,
    S_RELEASE = 2'b10
  } state_e;

  // Ceiling log2 for deriving widths from parameters; clog2(1) == 0.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    int unsigned span;
    result = 0;
    span   = 1;
    while (span < value) begin
      span   = span << 1;
      result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request after ptr, wrapping modulo NUM_REQ.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] win,
  output logic [IDX_W-1:0]   win_idx
);

  logic             found;
  logic [IDX_W-1:0] idx;

  always_comb begin
    win     = '0;
    win_idx = '0;
    found   = 1'b0;
    idx     = '0;
    // Offsets 1..NUM_REQ visit ptr last, so the previous winner has lowest priority.
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      idx = IDX_W'((32'(ptr) + i) % NUM_REQ);
      if (!found && req[idx]) begin
        found        = 1'b1;
        win[idx]     = 1'b1;
        win_idx      = idx;
      end
    end
  end

endmodule

// File: rtl/conv_engine_arbiter.sv
// Round-robin sharing of one conv2d engine: grants a requester, runs start/done, reports done/timeout.
module conv_engine_arbiter
  import conv_ctrl_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned TIMEOUT = 64,
  localparam int unsigned IDX_W  = (clog2(NUM_REQ) > 0) ? clog2(NUM_REQ) : 1,
  localparam int unsigned CNT_W  = clog2(TIMEOUT + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   gnt_idx,
  output logic               busy,
  output logic [NUM_REQ-1:0] req_done,
  output logic [NUM_REQ-1:0] req_err,
  output logic               eng_start,
  input  logic               eng_done
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  state_e               state_q;
  logic [NUM_REQ-1:0]   gnt_q;
  logic [IDX_W-1:0]     gnt_idx_q;
  logic                 busy_q;
  logic [NUM_REQ-1:0]   req_done_q;
  logic [NUM_REQ-1:0]   req_err_q;
  logic                 eng_start_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [IDX_W-1:0]     ptr_q;

  logic [NUM_REQ-1:0]   win;
  logic [IDX_W-1:0]     win_idx;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_arbiter (
    .req     (req),
    .ptr     (ptr_q),
    .win     (win),
    .win_idx (win_idx)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      gnt_q       <= '0;
      gnt_idx_q   <= '0;
      busy_q      <= 1'b0;
      req_done_q  <= '0;
      req_err_q   <= '0;
      eng_start_q <= 1'b0;
      cnt_q       <= '0;
      ptr_q       <= IDX_W'(NUM_REQ - 1);
    end else begin
      case (state_q)
        S_IDLE: begin
          if (|req) begin
            gnt_q       <= win;
            gnt_idx_q   <= win_idx;
            busy_q      <= 1'b1;
            eng_start_q <= 1'b1;
            cnt_q       <= '0;
            state_q     <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (cnt_q != CNT_MAX) begin
            cnt_q <= cnt_q + 1'b1;
          end
          // Done takes precedence over a coincident timeout.
          if (eng_done) begin
            eng_start_q <= 1'b0;
            req_done_q  <= gnt_q;
            state_q     <= S_RELEASE;
          end else if (cnt_q == CNT_LAST) begin
            eng_start_q <= 1'b0;
            req_err_q   <= gnt_q;
            state_q     <= S_RELEASE;
          end
        end
        S_RELEASE: begin
          // One idle cycle with start low lets the engine fall back from DONE to IDLE.
          req_done_q <= '0;
          req_err_q  <= '0;
          ptr_q      <= gnt_idx_q;
          gnt_q      <= '0;
          gnt_idx_q  <= '0;
          busy_q     <= 1'b0;
          state_q    <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign gnt       = gnt_q;
  assign gnt_idx   = gnt_idx_q;
  assign busy      = busy_q;
  assign req_done  = req_done_q;
  assign req_err   = req_err_q;
  assign eng_start = eng_start_q;

endmodule
